output_deskew: RTL

Collector at the bottom edge of the systolic array, the output-side counterpart of the input skew/lane-reversal stage. Result lanes leave the array staggered by one cycle per lane. This block delays each lane so the lanes realign, and optionally restores the original lane order. It then presents each result row as one aligned, registered word with a valid strobe, a row index and a last-row flag.

---
 rtl/output_deskew.sv | 119 +++++++++++
 1 files changed

// File: rtl/output_deskew.sv
// ============================================================================
// Module   : output_deskew
// Purpose  : Realigns the staggered result lanes leaving the systolic array
//            and optionally reverses their order. Emits each row as one
//            registered word with a valid strobe, a row index and a last flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_deskew #(
    parameter int LENGTH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int REVERSE    = 1,
    parameter int ROWS       = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic [LENGTH*DATA_WIDTH-1:0]              in_data,
    output logic                                      out_valid,
    output logic [LENGTH*DATA_WIDTH-1:0]              out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
    output logic                                      out_last
);

    localparam int c_cnt_w = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [DATA_WIDTH-1:0]        w_aligned [LENGTH];
    logic [LENGTH*DATA_WIDTH-1:0] w_mapped;
    logic                         w_tail;

    logic                         r_out_valid;
    logic [LENGTH*DATA_WIDTH-1:0] r_out_data;
    logic [c_cnt_w-1:0]           r_out_row_idx;
    logic                         r_out_last;
    logic [c_cnt_w-1:0]           r_cnt;

    // Lane i arrives i cycles late, so it waits LENGTH-1-i cycles to line up.
    for (genvar g = 0; g < LENGTH; g++) begin : g_lane
        localparam int c_depth = LENGTH - 1 - g;
        if (c_depth == 0) begin : g_pass
            assign w_aligned[g] = in_data[DATA_WIDTH*g +: DATA_WIDTH];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] r_dly [c_depth];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < c_depth; k++) begin
                        r_dly[k] <= '0;
                    end
                end else begin
                    r_dly[0] <= in_data[DATA_WIDTH*g +: DATA_WIDTH];
                    for (int k = 1; k < c_depth; k++) begin
                        r_dly[k] <= r_dly[k-1];
                    end
                end
            end
            assign w_aligned[g] = r_dly[c_depth-1];
        end
    end

    if (LENGTH > 1) begin : g_vpipe
        logic [LENGTH-2:0] r_vpipe;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vpipe <= '0;
            end else begin
                r_vpipe[0] <= in_valid;
                for (int k = 1; k < LENGTH - 1; k++) begin
                    r_vpipe[k] <= r_vpipe[k-1];
                end
            end
        end
        assign w_tail = r_vpipe[LENGTH-2];
    end else begin : g_vnone
        assign w_tail = in_valid;
    end

    always_comb begin
        w_mapped = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (REVERSE != 0) begin
                w_mapped[DATA_WIDTH*i +: DATA_WIDTH] = w_aligned[LENGTH-1-i];
            end else begin
                w_mapped[DATA_WIDTH*i +: DATA_WIDTH] = w_aligned[i];
            end
        end
    end

    // Index and last flag are registered alongside the row they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_row_idx <= '0;
            r_out_last    <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_out_valid <= w_tail;
            r_out_last  <= w_tail && (r_cnt == c_cnt_w'(ROWS - 1));
            if (w_tail) begin
                r_out_data    <= w_mapped;
                r_out_row_idx <= r_cnt;
                if (r_cnt == c_cnt_w'(ROWS - 1)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_row_idx = r_out_row_idx;
    assign out_last    = r_out_last;

endmodule

`default_nettype wire
